// File: rtl/hdc_ss_pkg.sv
// Shared definitions for the segmented-shift bind/unbind blocks of the
// sparse binary HDC datapath. Both the binder and the unbinder import
// this package so they agree on state encoding and default geometry.
package hdc_ss_pkg;

    // Default hypervector geometry: 32 segments of 32 bits each.
    localparam int SS_LENGTH_SEGMENT = 32;
    localparam int SS_NB_OF_SEGMENTS = 32;
    localparam int SS_D              = SS_LENGTH_SEGMENT * SS_NB_OF_SEGMENTS;

    // Segment-streaming controller states shared by bind and unbind.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        FIND = 3'd2,
        ROT  = 3'd3,
        OUT  = 3'd4,
        DONE = 3'd5
    } ss_state_e;

    // Width of an index addressing n items; never narrower than one bit.
    function automatic int ss_idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage : hdc_ss_pkg

// File: rtl/ss_index_encoder.sv
// One-hot to index priority encoder for a key segment.
// The lowest set bit wins; an all-zero vector encodes to index 0.
// With ONEHOT_CHECK_EN defined an extra flag reports whether the vector
// is exactly one-hot (neither zero nor multi-hot).
module ss_index_encoder
    import hdc_ss_pkg::*;
#(
    parameter int LENGTH_SEGMENT = SS_LENGTH_SEGMENT
) (
    input  logic [LENGTH_SEGMENT-1:0]               vec_i,
    output logic [ss_idx_width(LENGTH_SEGMENT)-1:0] idx_o
`ifdef ONEHOT_CHECK_EN
    ,
    output logic                                    onehot_o
`endif
);

    localparam int IW = ss_idx_width(LENGTH_SEGMENT);

    // Scan from the top down so the lowest set bit is the last one to
    // overwrite the index, giving lowest-bit priority.
    always_comb begin
        idx_o = '0;
        for (int i = LENGTH_SEGMENT - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

`ifdef ONEHOT_CHECK_EN
    localparam logic [LENGTH_SEGMENT-1:0] ONE_L = LENGTH_SEGMENT'(1);

    // Exactly one bit set: nonzero, and clearing the lowest set bit
    // leaves nothing behind.
    assign onehot_o = (vec_i != '0) && ((vec_i & (vec_i - ONE_L)) == '0);
`endif

endmodule : ss_index_encoder

// File: rtl/unbind_ss_basic.sv
// Segmented-shift unbind for sparse binary HDC.
// Recovers the original hypervector one segment at a time: each bound
// segment is rotated right by the position of the set bit of the
// matching key segment. Segment pairs are pulled from the register bank
// with a request/ready handshake identical to the bind path.
//
// Optional feature, enabled by defining ONEHOT_CHECK_EN:
//   adds the key_error output, a sticky flag raised when a captured key
//   segment is not exactly one-hot. It clears on the next accepted start.
//   The datapath is unaffected (the lowest set bit is always used).
module unbind_ss_basic
    import hdc_ss_pkg::*;
#(
    parameter int D              = SS_D,
    parameter int LENGTH_SEGMENT = SS_LENGTH_SEGMENT,
    parameter int NB_OF_SEGMENTS = SS_NB_OF_SEGMENTS
) (
    input  logic                                    clk,
    input  logic                                    arst_n_in,
    input  logic                                    start_new_hv,
    input  logic [LENGTH_SEGMENT-1:0]               segment_hv_a,
    input  logic [LENGTH_SEGMENT-1:0]               segment_hv_b,
    input  logic                                    new_sgmnts_ready,
    output logic                                    sgmnt_request,
    output logic [LENGTH_SEGMENT-1:0]               segment_hv_output,
    output logic                                    out_sgmnt_ready,
    output logic [ss_idx_width(NB_OF_SEGMENTS)-1:0] segment_index,
    output logic                                    busy,
    output logic                                    hv_done
`ifdef ONEHOT_CHECK_EN
    ,
    output logic                                    key_error
`endif
);

    localparam int IW = ss_idx_width(LENGTH_SEGMENT);
    localparam int CW = ss_idx_width(NB_OF_SEGMENTS);

    // Geometry sanity: the rotator relies on modulo-2^n index wrap, so
    // the segment length must be a power of two.
    if (D != LENGTH_SEGMENT * NB_OF_SEGMENTS) begin : g_bad_d
        $error("unbind_ss_basic: D must equal LENGTH_SEGMENT*NB_OF_SEGMENTS");
    end
    if ((LENGTH_SEGMENT < 2) || ((LENGTH_SEGMENT & (LENGTH_SEGMENT - 1)) != 0)) begin : g_bad_len
        $error("unbind_ss_basic: LENGTH_SEGMENT must be a power of two >= 2");
    end
    if (NB_OF_SEGMENTS < 2) begin : g_bad_nb
        $error("unbind_ss_basic: NB_OF_SEGMENTS must be >= 2");
    end

    ss_state_e                 state_q;
    logic [CW-1:0]             cnt_q;
    logic [LENGTH_SEGMENT-1:0] a_q;
    logic [LENGTH_SEGMENT-1:0] b_q;
    logic [IW-1:0]             idx_q;
    logic [IW-1:0]             idx_d;
    logic [LENGTH_SEGMENT-1:0] rot_d;
    logic [LENGTH_SEGMENT-1:0] out_q;
    logic [CW-1:0]             seg_idx_q;
    logic                      req_q;
    logic                      out_rdy_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      last_seg;

`ifdef ONEHOT_CHECK_EN
    logic                      onehot_d;
    logic                      key_err_q;
`endif

    // Key segment position lookup on the captured key.
    ss_index_encoder #(
        .LENGTH_SEGMENT (LENGTH_SEGMENT)
    ) u_index_encoder (
        .vec_i    (b_q),
        .idx_o    (idx_d)
`ifdef ONEHOT_CHECK_EN
        ,
        .onehot_o (onehot_d)
`endif
    );

    // Rotate right by the key position: bit i takes bit (i+idx) of the
    // bound segment, with the sum wrapping naturally in IW bits.
    for (genvar g = 0; g < LENGTH_SEGMENT; g++) begin : g_rot
        assign rot_d[g] = a_q[IW'(g) + idx_q];
    end

    assign last_seg = (cnt_q == CW'(NB_OF_SEGMENTS - 1));

    // Segment controller: one pass per segment through REQ, FIND, ROT and
    // OUT; every visible output is registered and updated on transitions.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            out_q     <= '0;
            seg_idx_q <= '0;
            req_q     <= 1'b0;
            out_rdy_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef ONEHOT_CHECK_EN
            key_err_q <= 1'b0;
`endif
        end else begin
            out_rdy_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_new_hv) begin
                        state_q <= REQ;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        req_q   <= 1'b1;
`ifdef ONEHOT_CHECK_EN
                        key_err_q <= 1'b0;
`endif
                    end
                end
                REQ: begin
                    if (new_sgmnts_ready) begin
                        a_q     <= segment_hv_a;
                        b_q     <= segment_hv_b;
                        req_q   <= 1'b0;
                        state_q <= FIND;
                    end
                end
                FIND: begin
                    idx_q   <= idx_d;
                    state_q <= ROT;
                end
                ROT: begin
                    out_q     <= rot_d;
                    seg_idx_q <= cnt_q;
                    out_rdy_q <= 1'b1;
                    state_q   <= OUT;
`ifdef ONEHOT_CHECK_EN
                    if (!onehot_d) begin
                        key_err_q <= 1'b1;
                    end
`endif
                end
                OUT: begin
                    if (last_seg) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sgmnt_request     = req_q;
    assign segment_hv_output = out_q;
    assign out_sgmnt_ready   = out_rdy_q;
    assign segment_index     = seg_idx_q;
    assign busy              = busy_q;
    assign hv_done           = done_q;
`ifdef ONEHOT_CHECK_EN
    assign key_error         = key_err_q;
`endif

endmodule : unbind_ss_basic

// File: tb/tb_unbind_ss_basic.sv
// Self-checking bench for unbind_ss_basic. Expected segments come from a
// behavioural model: keys are random one-hot words, the model binds a
// random original by rotating left, and the unbound output must equal
// the original. Directed segments cover shift, wrap, multi-hot and zero
// keys, handshake stalls, ignored restarts and a mid-hypervector reset.
module tb_unbind_ss_basic;

    localparam int L  = 32;
    localparam int NB = 32;

    logic          clk;
    logic          arstN;
    logic          startIn;
    logic [L-1:0]  segA;
    logic [L-1:0]  segB;
    logic          newReady;
    logic          sgmntRequest;
    logic [L-1:0]  segOut;
    logic          outReady;
    logic [4:0]    segIndex;
    logic          busyOut;
    logic          hvDone;
`ifdef ONEHOT_CHECK_EN
    logic          keyError;
    logic          keyErrExp;
`endif

    int totalCount;
    int badCount;

    unbind_ss_basic dut (
        .clk               (clk),
        .arst_n_in         (arstN),
        .start_new_hv      (startIn),
        .segment_hv_a      (segA),
        .segment_hv_b      (segB),
        .new_sgmnts_ready  (newReady),
        .sgmnt_request     (sgmntRequest),
        .segment_hv_output (segOut),
        .out_sgmnt_ready   (outReady),
        .segment_index     (segIndex),
        .busy              (busyOut),
        .hv_done           (hvDone)
`ifdef ONEHOT_CHECK_EN
        ,
        .key_error         (keyError)
`endif
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a stuck design still ends the run.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalCount++;
        if (got !== exp) begin
            badCount++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: position of the lowest set bit, 0 for an empty key.
    function automatic int keyPos(input logic [L-1:0] k);
        for (int i = 0; i < L; i++) begin
            if (k[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [L-1:0] rotRight(input logic [L-1:0] v, input int p);
        return (v >> p) | (v << ((L - p) % L));
    endfunction

    function automatic logic [L-1:0] rotLeft(input logic [L-1:0] v, input int p);
        return rotRight(v, (L - p) % L);
    endfunction

    task automatic checkResetState();
        checkOutput("rst_req",   64'(sgmntRequest), 64'd0);
        checkOutput("rst_out",   64'(segOut),       64'd0);
        checkOutput("rst_ready", 64'(outReady),     64'd0);
        checkOutput("rst_index", 64'(segIndex),     64'd0);
        checkOutput("rst_busy",  64'(busyOut),      64'd0);
        checkOutput("rst_done",  64'(hvDone),       64'd0);
`ifdef ONEHOT_CHECK_EN
        checkOutput("rst_keyerr", 64'(keyError),    64'd0);
`endif
    endtask

    // Pulse start from IDLE; returns at the first negedge in REQ.
    task automatic startHv();
        @(negedge clk);
        startIn = 1'b1;
        @(negedge clk);
        startIn = 1'b0;
        checkOutput("start_busy", 64'(busyOut),      64'd1);
        checkOutput("start_req",  64'(sgmntRequest), 64'd1);
`ifdef ONEHOT_CHECK_EN
        keyErrExp = 1'b0;
        checkOutput("start_keyerr", 64'(keyError), 64'(keyErrExp));
`endif
    endtask

    // Hand one segment pair over and check the unbound result, latency
    // and index; returns at the negedge of the output-valid cycle.
    task automatic applyStimulus(input logic [L-1:0] a, input logic [L-1:0] b,
                                 input logic [L-1:0] expOut, input int expIdx);
        int waitCnt;
        int lat;
        waitCnt = 0;
        while (sgmntRequest !== 1'b1 && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (sgmntRequest !== 1'b1) begin
            checkOutput("req_timeout", 64'd0, 64'd1);
            return;
        end
        segA     = a;
        segB     = b;
        newReady = 1'b1;
        @(posedge clk);
        #1;
        newReady = 1'b0;
        segA     = $urandom;
        segB     = $urandom;
        lat = 1;
        @(negedge clk);
        while (outReady !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency",   64'(lat),      64'd3);
        checkOutput("seg_out",   64'(segOut),   64'(expOut));
        checkOutput("seg_index", 64'(segIndex), 64'(expIdx));
        checkOutput("seg_busy",  64'(busyOut),  64'd1);
        checkOutput("seg_nodone", 64'(hvDone),  64'd0);
`ifdef ONEHOT_CHECK_EN
        if (b == '0 || (b & (b - 1)) != '0) keyErrExp = 1'b1;
        checkOutput("seg_keyerr", 64'(keyError), 64'(keyErrExp));
`endif
    endtask

    // Last segment has just been output: expect the done pulse next.
    task automatic finishHv();
        @(negedge clk);
        checkOutput("hv_done",     64'(hvDone),       64'd1);
        checkOutput("busy_done",   64'(busyOut),      64'd0);
        @(negedge clk);
        checkOutput("done_pulse",  64'(hvDone),       64'd0);
        checkOutput("idle_req",    64'(sgmntRequest), 64'd0);
    endtask

    task automatic roundTripSeg(input int idx);
        logic [L-1:0] orig;
        logic [L-1:0] key;
        int           p;
        orig = $urandom;
        p    = $urandom_range(L - 1, 0);
        key  = 32'h1 << p;
        applyStimulus(rotLeft(orig, keyPos(key)), key, orig, idx);
    endtask

    task automatic runRoundTripHv();
        startHv();
        for (int s = 0; s < NB; s++) begin
            roundTripSeg(s);
        end
        finishHv();
    endtask

    initial begin
        bit reqHeld;
        bit noOut;
        bit outHeld;
        bit sawDone;
        bit allIdle;
        totalCount = 0;
        badCount   = 0;
        arstN      = 1'b0;
        startIn    = 1'b0;
        segA       = '0;
        segB       = '0;
        newReady   = 1'b0;
`ifdef ONEHOT_CHECK_EN
        keyErrExp  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checkResetState();
        arstN = 1'b1;

        // First hypervector: directed segments, then round trips.
        startHv();
        applyStimulus(32'h0000_0100, 32'h0000_0010, 32'h0000_0010, 0);

        // Stall in REQ for 10 cycles with a stray start pulse.
        @(negedge clk);
        reqHeld = 1'b1;
        noOut   = 1'b1;
        outHeld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (sgmntRequest !== 1'b1) reqHeld = 1'b0;
            if (outReady !== 1'b0) noOut = 1'b0;
            if (segOut !== 32'h0000_0010) outHeld = 1'b0;
            startIn = (i == 4);
            @(negedge clk);
        end
        startIn = 1'b0;
        checkOutput("stall_req",   64'(reqHeld), 64'd1);
        checkOutput("stall_noout", 64'(noOut),   64'd1);
        checkOutput("stall_hold",  64'(outHeld), 64'd1);

        applyStimulus(32'h0000_0001, 32'h0000_0002, 32'h8000_0000, 1);
        applyStimulus(32'h0000_0100, 32'h0000_0006, 32'h0000_0080, 2);
        applyStimulus(32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 3);
        for (int s = 4; s < NB; s++) begin
            roundTripSeg(s);
        end
        finishHv();

        // Second hypervector: pure round trip; start clears any key error.
        runRoundTripHv();

        // Reset in the middle of segment 5.
        startHv();
        for (int s = 0; s < 5; s++) begin
            roundTripSeg(s);
        end
        @(negedge clk);
        segA     = $urandom;
        segB     = 32'h0000_0001;
        newReady = 1'b1;
        @(posedge clk);
        #1;
        newReady = 1'b0;
        @(negedge clk);
        arstN = 1'b0;
        #1;
        checkResetState();
        sawDone = 1'b0;
        allIdle = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 3) arstN = 1'b1;
            if (hvDone !== 1'b0) sawDone = 1'b1;
            if (busyOut !== 1'b0 || sgmntRequest !== 1'b0) allIdle = 1'b0;
        end
        checkOutput("rst_nodone", 64'(sawDone), 64'd0);
        checkOutput("rst_idle",   64'(allIdle), 64'd1);

        // Fresh hypervector after reset restarts at segment 0.
        runRoundTripHv();

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule : tb_unbind_ss_basic
